// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and data access.
// Optional STARVE_GUARD_EN bounds how many data grants may pass a waiting fetch.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam logic [3:0] LatInit = 4'(MEM_LATENCY);
  // Out-of-range configurations never grant, so misuse shows up immediately.
  localparam bit CfgOk = (MEM_LATENCY >= 1) && (MEM_LATENCY <= 15) &&
                         (STARVE_LIMIT >= 1) && (STARVE_LIMIT <= 15);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t     state;
  logic [3:0] latCnt;
  logic       owner;
  logic       reqWe;
  logic       anyReq;
  logic       grantData;

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = d_req & ~d_ready;
  assign anyReq    = (if_req | d_req) & CfgOk;

`ifdef STARVE_GUARD_EN
  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);
  logic [3:0] starveCnt;
  assign grantData = d_req & ~(if_req & (starveCnt == StarveMax));
`else
  assign grantData = d_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      latCnt    <= '0;
      owner     <= 1'b0;
      reqWe     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
`ifdef STARVE_GUARD_EN
      starveCnt <= '0;
`endif
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            owner     <= grantData;
            reqWe     <= grantData & d_we;
            mem_en    <= 1'b1;
            mem_we    <= grantData & d_we;
            mem_addr  <= grantData ? d_addr : if_addr;
            mem_wdata <= grantData ? d_wdata : '0;
            state     <= ISSUE;
`ifdef STARVE_GUARD_EN
            if (!grantData)
              starveCnt <= '0;
            else if (if_req)
              starveCnt <= starveCnt + 4'd1;
`endif
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          latCnt <= LatInit;
          state  <= WAIT;
        end
        WAIT: begin
          latCnt <= latCnt - 4'd1;
          // Count hits zero this cycle: memory data is valid right now.
          if (latCnt == 4'd1) begin
            if (!reqWe) begin
              if (owner) d_rdata  <= mem_rdata;
              else       if_rdata <= mem_rdata;
            end
            if (owner) d_ready  <= 1'b1;
            else       if_ready <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of both requesters and the memory port.
REQ-002 Parameter DATA_W, default 32, data width of both requesters and the memory port.
REQ-003 Parameter MEM_LATENCY, default 2 (legal 1..15), cycles from the mem_en cycle to the cycle in which mem_rdata is valid.
REQ-004 Parameter STARVE_LIMIT, default 4 (legal 1..15), consecutive data grants allowed while a fetch waits (only when STARVE_GUARD_EN is defined).
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  reset is synchronous and active-high.
REQ-007 if_req  in  1  instruction-fetch request; held high until if_ready.
REQ-008 if_addr  in  ADDR_W  fetch address.
REQ-009 if_rdata  out  DATA_W  fetched instruction; registered.
REQ-010 if_ready  out  1  one-cycle fetch-completion pulse.
REQ-011 d_req / d_we  in  1 / 1  data request, write enable; request held high until d_ready.
REQ-012 d_addr / d_wdata  in  ADDR_W / DATA_W  data address, write data.
REQ-013 d_rdata  out  DATA_W  load data; registered.
REQ-014 d_ready  out  1  one-cycle data-completion pulse.
REQ-015 mem_en / mem_we  out  1 / 1  single-port memory access strobe, write enable.
REQ-016 mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address, write data.
REQ-017 mem_rdata  in  DATA_W  memory read data.
REQ-018 stall_if / stall_mem  out  1 / 1  combinational: if_req&~if_ready and d_req&~d_ready; drive PC/IF-ID hold and full-pipeline hold.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE, plus a 4-bit latency counter and a 1-bit owner register (0 = fetch, 1 = data).
REQ-020 In IDLE with any request, the block SHALL grant on the edge, latch owner, addr, we and wdata, and go to ISSUE; with no request it SHALL stay in IDLE.
REQ-021 On simultaneous if_req and d_req, data SHALL win (older instruction), subject to REQ-031.
REQ-022 In ISSUE, the block SHALL assert mem_en for exactly one cycle with the latched values and load the counter with MEM_LATENCY; mem_we SHALL be 0 for fetch.
REQ-023 WAIT SHALL decrement the counter; in the cycle the count reaches 0, it SHALL capture mem_rdata into if_rdata or d_rdata (reads only) and go to DONE.
REQ-024 In DONE, the block SHALL pulse the owner's ready for one cycle, ignore all requests, and return to IDLE.
REQ-025 Latency: request first seen in IDLE in cycle T gives mem_en in T+1, mem_rdata sampled in T+1+MEM_LATENCY, and ready in T+2+MEM_LATENCY.
REQ-026 A write SHALL complete with d_ready, and d_rdata SHALL stay unchanged.
REQ-027 if_rdata and d_rdata SHALL hold their last value until the next read completion for that owner.
REQ-028 Changes to addr, we or wdata after the grant SHALL be ignored; a request dropped mid-transaction SHALL still complete and pulse ready.
REQ-029 mem_en, mem_we, if_ready and d_ready SHALL never be asserted in any cycle other than those stated, and if_ready and d_ready SHALL never be high together.

Reset
REQ-030 On reset the block SHALL go to IDLE and zero the counter, owner, starvation count, all registered outputs, if_rdata and d_rdata; an in-flight access SHALL be discarded, with no ready pulse and any later mem_rdata ignored.

Configuration
REQ-031 With STARVE_GUARD_EN defined, a 4-bit count SHALL increment on each data grant made while if_req is high and clear on any fetch grant; when it equals STARVE_LIMIT, the next simultaneous arbitration SHALL grant fetch; without the macro, strict data priority SHALL apply and the count SHALL not exist.

Verification (MEM_LATENCY=2, STARVE_LIMIT=2)
REQ-032 Case 1: fetch-only read, if_req=1 and if_addr=0x40 in cycle 0, memory returns 0x8C010004 -> mem_en=1 with mem_addr=0x40 in cycle 1; if_ready=1 and if_rdata=0x8C010004 in cycle 4; stall_if=1 in cycles 0-3.
REQ-033 Case 2: simultaneous requests, cycle 0 with d_addr=0x10 (read) and if_addr=0x44 -> data mem_en in cycle 1 and d_ready in cycle 4; fetch mem_en in cycle 6 and if_ready in cycle 9.
REQ-034 Case 3: data write, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF -> mem_en=mem_we=1 with those values in cycle 1; d_ready in cycle 4; d_rdata unchanged.
REQ-035 Case 4: reset asserted in cycle 2 of a read -> no ready pulse; all outputs are 0 in cycle 3; a new request in cycle 3 is served normally.
REQ-036 Case 5: d_req held continuously with if_req high -> with STARVE_GUARD_EN the third grant goes to fetch; without the macro fetch is never granted while d_req stays high.
